// File: rtl/imem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for the program loader.
// The master drives the program stream; the slave is the loader itself.
interface imem_loader_if #(
  parameter int AW = 10
);
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [AW:0]   word_count;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_rst_l;

  modport master (
    output start, in_data, in_valid, in_last,
    input  in_ready, we, waddr, wdata, word_count, busy, done, err, cpu_rst_l
  );

  modport slave (
    input  start, in_data, in_valid, in_last,
    output in_ready, we, waddr, wdata, word_count, busy, done, err, cpu_rst_l
  );
endinterface

// File: rtl/imem_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them into the
// instruction memory from address 0, holding the core in reset until the load ends.
module imem_loader #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_buf;
  logic [AW-1:0] ptr;
  logic [AW:0]   word_count_q;
  logic          err_q;
  logic          last_q;

  logic accept;
  logic at_end;
  logic restart;

  assign accept  = (state == LOAD) && bus.in_valid;
  assign at_end  = (ptr == LAST_ADDR);
  assign restart = ((state == IDLE) || (state == DONE)) && bus.start;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (bus.start) state_nxt = LOAD;
      LOAD:  if (accept && ((byte_cnt == 2'd3) || bus.in_last)) state_nxt = WRITE;
      WRITE: state_nxt = (last_q || at_end) ? DONE : LOAD;
      DONE:  if (bus.start) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Unfilled bytes of a short final word read as zero because the buffer is
  // cleared after every write and on every (re)start.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt     <= '0;
      word_buf     <= '0;
      ptr          <= '0;
      word_count_q <= '0;
      err_q        <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      if (restart) begin
        byte_cnt     <= '0;
        word_buf     <= '0;
        ptr          <= '0;
        word_count_q <= '0;
        err_q        <= 1'b0;
        last_q       <= 1'b0;
      end
      if (accept) begin
        word_buf[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
        byte_cnt <= bus.in_last ? 2'd0 : byte_cnt + 2'd1;
        last_q   <= bus.in_last;
      end
      if (state == WRITE) begin
        word_buf     <= '0;
        word_count_q <= word_count_q + 1'b1;
        // The pointer saturates at the top address: the FSM leaves for DONE there.
        if (!at_end) ptr <= ptr + 1'b1;
        if (at_end && !last_q) err_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready   = (state == LOAD);
  assign bus.we         = (state == WRITE);
  assign bus.waddr      = (state == WRITE) ? ptr : '0;
  assign bus.wdata      = (state == WRITE) ? word_buf : '0;
  assign bus.word_count = word_count_q;
  assign bus.busy       = (state == LOAD) || (state == WRITE);
  assign bus.done       = (state == DONE);
  assign bus.err        = err_q;
  assign bus.cpu_rst_l  = (state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench: a default-depth loader plus a 4-word loader for the overflow cases,
// both fed the same byte stream; writes are captured from the memory port.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  bit         gappy = 1'b0;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  logic [9:0]  mq_a[$];
  logic [31:0] mq_d[$];
  logic [1:0]  sq_a[$];
  logic [31:0] sq_d[$];

  imem_loader_if #(.AW(10)) bm ();
  imem_loader_if #(.AW(2))  bs ();

  assign bm.start = start;   assign bs.start = start;
  assign bm.in_data = in_data; assign bs.in_data = in_data;
  assign bm.in_valid = in_valid; assign bs.in_valid = in_valid;
  assign bm.in_last = in_last; assign bs.in_last = in_last;

  imem_loader #(.DEPTH(1024), .AW(10)) dut_m (.clk(clk), .rst(rst), .bus(bm));
  imem_loader #(.DEPTH(4),    .AW(2))  dut_s (.clk(clk), .rst(rst), .bus(bs));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bm.we) begin mq_a.push_back(bm.waddr); mq_d.push_back(bm.wdata); end
    else if (bm.waddr != '0 || bm.wdata != '0) viol++;
    if (bs.we) begin sq_a.push_back(bs.waddr); sq_d.push_back(bs.wdata); end
    else if (bs.waddr != '0 || bs.wdata != '0) viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bs.in_ready : bm.in_ready;
  endfunction

  task automatic send_byte(input logic [7:0] d, input logic last, input bit sel);
    int n = 0;
    if (gappy) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!rdy(sel) && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) check("rdy_timeout", n, 0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit sel);
    int n = 0;
    while (!(sel ? bs.done : bm.done) && n < 50) begin @(negedge clk); n++; end
    check({tag, "_done"}, sel ? bs.done : bm.done, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, bm.in_ready, 0);
    check({tag, "_we"}, bm.we, 0);
    check({tag, "_waddr_wdata"}, {bm.waddr, bm.wdata}, 0);
    check({tag, "_word_count"}, bm.word_count, 0);
    check({tag, "_busy_done_err"}, {bm.busy, bm.done, bm.err}, 0);
    check({tag, "_cpu_rst_l"}, bm.cpu_rst_l, 0);
  endtask

  task automatic clear_q();
    mq_a.delete(); mq_d.delete(); sq_a.delete(); sq_d.delete();
  endtask

  logic [7:0] s2_bytes [8] = '{8'h03, 8'hA3, 8'hC4, 8'hFF, 8'h23, 8'hA4, 8'h64, 8'h00};

  initial begin
    @(negedge clk);
    apply_reset();
    check_reset_outputs("rst");

    // Scenario 1: single word with last on the 4th byte
    clear_q();
    pulse_start();
    check("s1_load_busy_ready", {bm.busy, bm.in_ready, bm.cpu_rst_l}, 3'b110);
    send_byte(8'h33, 0, 0); send_byte(8'hE2, 0, 0); send_byte(8'h62, 0, 0);
    send_byte(8'h00, 1, 0);
    check("s1_we_latency", {bm.we, bm.busy}, 2'b11);
    wait_done("s1", 0);
    check("s1_nwrites", mq_a.size(), 1);
    if (mq_a.size() == 1) check("s1_write", {mq_a[0], mq_d[0]}, {10'd0, 32'h0062E233});
    check("s1_word_count", bm.word_count, 1);
    check("s1_err_cpu", {bm.err, bm.cpu_rst_l, bm.busy}, 3'b010);

    // Scenario 2: two words, restart from DONE
    clear_q();
    pulse_start();
    check("s2_restart", {bm.word_count, bm.done, bm.cpu_rst_l}, 0);
    for (int i = 0; i < 8; i++) send_byte(s2_bytes[i], i == 7, 0);
    wait_done("s2", 0);
    check("s2_nwrites", mq_a.size(), 2);
    if (mq_a.size() == 2) begin
      check("s2_w0", {mq_a[0], mq_d[0]}, {10'd0, 32'hFFC4A303});
      check("s2_w1", {mq_a[1], mq_d[1]}, {10'd1, 32'h0064A423});
    end
    check("s2_word_count", bm.word_count, 2);

    // Scenario 3: last on the 2nd byte zero-fills the upper bytes
    clear_q();
    pulse_start();
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 1, 0);
    wait_done("s3", 0);
    check("s3_nwrites", mq_a.size(), 1);
    if (mq_a.size() == 1) check("s3_write", {mq_a[0], mq_d[0]}, {10'd0, 32'h0000BBAA});
    check("s3_err", bm.err, 0);

    // Scenario 4: fill a 4-word memory without last, then with last on byte 16
    clear_q();
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 0, 1);
    wait_done("s4a", 1);
    check("s4a_err", bs.err, 1);
    check("s4a_word_count", bs.word_count, 4);
    check("s4a_nwrites", sq_a.size(), 4);
    for (int i = 0; i < sq_a.size() && i < 4; i++)
      check($sformatf("s4a_w%0d", i), {sq_a[i], sq_d[i]},
            {2'(i), 8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)});
    in_valid = 1'b1; in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      check("s4a_no_ready", {bs.in_ready, bs.done}, 2'b01);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("s4a_no_extra_write", sq_a.size(), 4);
    check("s4a_err_hold", {bs.err, bs.word_count}, {1'b1, 3'd4});
    clear_q();
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), i == 15, 1);
    wait_done("s4b", 1);
    check("s4b_err", bs.err, 0);
    check("s4b_nwrites", sq_a.size(), 4);
    if (sq_a.size() == 4) check("s4b_w3", {sq_a[3], sq_d[3]}, {2'd3, 32'h100F0E0D});

    // Scenario 5: reset in the middle of the second word
    apply_reset();
    clear_q();
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0, 0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check_reset_outputs("s5_rst");
    repeat (3) @(negedge clk);
    check("s5_nwrites", mq_a.size(), 1);
    if (mq_a.size() == 1) check("s5_w0", {mq_a[0], mq_d[0]}, {10'd0, 32'h04030201});
    clear_q();
    pulse_start();
    send_byte(8'h0A, 0, 0); send_byte(8'h0B, 0, 0); send_byte(8'h0C, 0, 0); send_byte(8'h0D, 0, 0);
    repeat (2) @(negedge clk);
    check("s5_nwrites2", mq_a.size(), 1);
    if (mq_a.size() == 1) check("s5_w_after", {mq_a[0], mq_d[0]}, {10'd0, 32'h0D0C0B0A});

    // Scenario 6: gappy valid, start ignored mid-LOAD, restart from DONE
    apply_reset();
    clear_q();
    gappy = 1'b1;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_byte(s2_bytes[i], i == 7, 0);
      if (i == 2) pulse_start();
    end
    wait_done("s6", 0);
    check("s6_nwrites", mq_a.size(), 2);
    if (mq_a.size() == 2) begin
      check("s6_w0", {mq_a[0], mq_d[0]}, {10'd0, 32'hFFC4A303});
      check("s6_w1", {mq_a[1], mq_d[1]}, {10'd1, 32'h0064A423});
    end
    check("s6_word_count", bm.word_count, 2);
    clear_q();
    pulse_start();
    check("s6_restart", {bm.word_count, bm.done, bm.busy, bm.err}, {11'd0, 3'b010});
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0); send_byte(8'h33, 0, 0); send_byte(8'h44, 1, 0);
    wait_done("s6b", 0);
    check("s6b_nwrites", mq_a.size(), 1);
    if (mq_a.size() == 1) check("s6b_w0", {mq_a[0], mq_d[0]}, {10'd0, 32'h44332211});
    check("s6b_word_count", bm.word_count, 1);
    gappy = 1'b0;

    check("bus_zero_when_idle", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
